// File: rtl/narrow_pkg.sv
// Shared definitions for the 34->32 signed narrowing stage: widths,
// saturation limits, the S1 payload type and the overflow predicate.
package narrow_pkg;

  localparam int NARROW_W_IN  = 34;
  localparam int NARROW_W_OUT = 32;

  localparam logic signed [NARROW_W_OUT-1:0] SAT_POS = 32'sh7FFF_FFFF;
  localparam logic signed [NARROW_W_OUT-1:0] SAT_NEG = 32'sh8000_0000;

  typedef struct packed {
    logic signed [NARROW_W_IN-1:0] data;
    logic                          ovf;
  } s1_payload_t;

  // A 34-bit value fits in 32 signed bits only when bits [33:31] are all equal.
  function automatic logic narrow_ovf(input logic signed [NARROW_W_IN-1:0] d);
    logic [2:0] top3;
    top3 = d[NARROW_W_IN-1 -: 3];
    return !((top3 == 3'b000) || (top3 == 3'b111));
  endfunction

endpackage

// File: rtl/narrow_ovf_check.sv
// Combinational overflow detect and narrowing of a 34-bit signed value.
// Build option NARROW_SAT_EN: when defined, overflowed values clamp to the
// signed 32-bit limits; otherwise the upper bits are simply dropped.
module narrow_ovf_check
  import narrow_pkg::*;
(
  input  logic signed [NARROW_W_IN-1:0]  data_i,
  output logic                           ovf_o,
  output logic signed [NARROW_W_OUT-1:0] narrow_o
);

  logic ovf;

  // Overflow flag and the narrowed result (clamped or truncated).
  always_comb begin
    ovf   = narrow_ovf(data_i);
    ovf_o = ovf;
`ifdef NARROW_SAT_EN
    narrow_o = ovf ? (data_i[NARROW_W_IN-1] ? SAT_NEG : SAT_POS) : data_i[NARROW_W_OUT-1:0];
`else
    narrow_o = data_i[NARROW_W_OUT-1:0];
`endif
  end

endmodule

// File: rtl/narrow_34to32.sv
// Two-stage valid/ready narrowing pipeline from the 34-bit arithmetic
// result to 32-bit writeback width, with sticky and saturating-count
// overflow statistics. Build option NARROW_SAT_EN selects saturation
// (defined) or wrap/truncate (undefined) for overflowed beats.
module narrow_34to32
  import narrow_pkg::*;
#(
  parameter int W_IN  = 34,
  parameter int W_OUT = 32,
  parameter int CNT_W = 8
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [W_IN-1:0]  in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [W_OUT-1:0] out_data,
  output logic                    out_ovf,
  input  logic                    clr_stats,
  output logic                    ovf_sticky,
  output logic [CNT_W-1:0]        ovf_count
);

  s1_payload_t             s1_d, s1_q;
  logic                    vld_p1_q, vld_p2_q;
  logic signed [W_OUT-1:0] data_p2_q;
  logic                    ovf_p2_q;
  logic                    sticky_d, sticky_q;
  logic [CNT_W-1:0]        count_d, count_q;

  logic                    s2_adv, s1_mv, accept, deliver;
  logic                    chk_ovf;
  logic signed [W_OUT-1:0] chk_narrow;

  // Handshake: S2 frees when empty or draining; S1 frees when empty or moving.
  always_comb begin
    s2_adv   = !vld_p2_q || out_ready;
    s1_mv    = vld_p1_q && s2_adv;
    in_ready = !vld_p1_q || s2_adv;
    accept   = in_valid && in_ready;
    deliver  = vld_p2_q && out_ready;
    s1_d     = '{data: in_data, ovf: narrow_ovf(in_data)};
  end

  // ---- stage 0 -> S1 boundary ----
  // S1 payload carries no reset; its valid bit alone qualifies it.
  always_ff @(posedge clock) begin
    if (accept) s1_q <= s1_d;
  end

  narrow_ovf_check u_chk (
    .data_i   (s1_q.data),
    .ovf_o    (chk_ovf),
    .narrow_o (chk_narrow)
  );

  // ---- S1 -> S2 boundary ----
  // Valids and the S2 output beat; S2 data only loads when S1 moves in.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      data_p2_q <= '0;
      ovf_p2_q  <= 1'b0;
    end else begin
      if (accept)     vld_p1_q <= 1'b1;
      else if (s1_mv) vld_p1_q <= 1'b0;
      if (s2_adv)     vld_p2_q <= vld_p1_q;
      if (s1_mv) begin
        data_p2_q <= chk_narrow;
        ovf_p2_q  <= s1_q.ovf;
      end
    end
  end

  // Statistics next state: clear dominates a same-cycle overflowed delivery.
  always_comb begin
    sticky_d = sticky_q;
    count_d  = count_q;
    if (clr_stats) begin
      sticky_d = 1'b0;
      count_d  = '0;
    end else if (deliver && ovf_p2_q) begin
      sticky_d = 1'b1;
      if (count_q != {CNT_W{1'b1}}) count_d = count_q + 1'b1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sticky_q <= 1'b0;
      count_q  <= '0;
    end else begin
      sticky_q <= sticky_d;
      count_q  <= count_d;
    end
  end

  // The registered S1 flag and the checker must agree on the same data.
  a_ovf_consistent: assert property (@(posedge clock) disable iff (!resetn)
    vld_p1_q |-> (chk_ovf == s1_q.ovf));

  assign out_valid  = vld_p2_q;
  assign out_data   = data_p2_q;
  assign out_ovf    = ovf_p2_q;
  assign ovf_sticky = sticky_q;
  assign ovf_count  = count_q;

endmodule

// File: doc/narrow_34to32.md
# narrow_34to32

Pipelined signed narrowing stage: the inverse of the 32→34 sign extender. It accepts 34-bit signed results from the datapath, such as the multiplier/divider partial-product path, and returns them to 32-bit register-file width. It detects overflow when bits [33:31] disagree. It saturates or wraps according to the build configuration. It keeps sticky and counted overflow statistics. It sits between the 34-bit arithmetic unit and the writeback mux, with a valid/ready handshake on both sides.

## Interface
- `W_IN`, 34, input width (fixed; only 34 supported)
- `W_OUT`, 32, output width (fixed; only 32 supported)
- `CNT_W`, 8, overflow event counter width
- `clock`  in  1  rising-edge clock
- `resetn`  in  1  reset, asynchronous and active-low
- `in_valid`  in  1  upstream beat valid
- `in_ready`  out  1  stage can accept a beat this cycle
- `in_data`  in  34  signed value
- `out_valid`  out  1  output beat valid
- `out_ready`  in  1  downstream accepts
- `out_data`  out  32  narrowed value
- `out_ovf`  out  1  this beat overflowed 32-bit signed range
- `clr_stats`  in  1  synchronous clear of `ovf_sticky` and `ovf_count`
- `ovf_sticky`  out  1  set by any delivered overflowed beat
- `ovf_count`  out  CNT_W  saturating count of delivered overflowed beats

## Operation
- Overflow condition: `in_data[33:31]` is not all-ones and not all-zeros.
- Stage 1 (S1) registers `in_data` and a computed `ovf` bit.
- Stage 2 (S2) registers the narrowed `out_data` and `out_ovf`.
- Narrowing without overflow: `out_data = in_data[31:0]`.
- Narrowing with overflow depends on the configuration (see Configuration).
- Handshake:
  - `s2_adv = !out_valid || out_ready`
  - S1 moves to S2 when `s1_valid && s2_adv`
  - `in_ready = !s1_valid || s2_adv` (combinational from `out_ready`; accepted)
  - Accept occurs on `in_valid && in_ready`.
- Delivered beat: `out_valid && out_ready`. `out_data` and `out_ovf` hold stable while `out_valid && !out_ready`.
- Statistics:
  - On a delivered beat with `out_ovf=1`: `ovf_sticky` ← 1 and `ovf_count` increments, saturating at 2^CNT_W−1 with no wrap.
  - `clr_stats` sets both statistics to 0. If a clear and an increment fall in the same cycle, the clear wins (result 0, sticky 0).
- Reset (any time, including mid-transfer):
  - all valids 0, `out_data` 0, `out_ovf` 0, `ovf_sticky` 0, `ovf_count` 0
  - `in_ready` becomes 1 once reset deasserts
  - in-flight beats are discarded.

## Timing
- Latency: a beat accepted at edge N presents `out_valid` after edge N+1 and is visible in cycle N+2 if not stalled.
- Throughput: 1 beat/cycle when `out_ready` is held high.
- Full condition: S1 and S2 both valid and `out_ready=0`, so `in_ready=0`. Holds 2 beats max.
- Releasing `out_ready` for one cycle with the pipeline full advances both stages in that edge, and `in_ready=1` in the same cycle.
- Statistics update on the edge of the delivery and are visible the next cycle.

## Configuration
- `NARROW_SAT_EN` defined: on overflow, saturate. If `in_data[33]=0`, output 0x7FFFFFFF; if `in_data[33]=1`, output 0x80000000.
- Not defined: wrap/truncate, so `out_data = in_data[31:0]` always.
- `out_ovf` and the statistics behave identically in both builds.

## Structure
- Shared package `narrow_pkg`:
  - constants `NARROW_W_IN=34`, `NARROW_W_OUT=32`
  - `SAT_POS=32'h7FFFFFFF`, `SAT_NEG=32'h80000000`
  - typedef of the S1 payload struct {data[33:0], ovf}.
- One combinational sub-module `narrow_ovf_check`: 34-bit in, returns `ovf` and the narrowed 32-bit value, with the macro applied inside. Handshake and statistics stay in the top module.

## Test plan
- Steady stream with `out_ready=1`: inputs 0x000000005, 0x3FFFFFFFB (−5), 0x07FFFFFFF → outputs 0x00000005, 0xFFFFFFFB, 0x7FFFFFFF two cycles later, `out_ovf=0`, one per cycle.
- Overflow: input 0x080000000 → SAT build 0x7FFFFFFF, wrap build 0x80000000. Input 0x37FFFFFFF → SAT build 0x80000000, wrap build 0x7FFFFFFF. `out_ovf=1` both; `ovf_count` 0→1→2; `ovf_sticky=1`.
- Backpressure: `out_ready=0` with 3 offered beats → 2 accepted, `in_ready=0`, `out_data` stable. Releasing `out_ready` delivers them in order with no loss or duplication.
- Counter saturation: 300 overflowed beats → `ovf_count`=255. A `clr_stats` pulse coinciding with an overflowed delivery → count 0, sticky 0.
- Mid-operation reset: `resetn` pulled low with 2 beats in flight → `out_valid`=0 immediately (asynchronous), stats 0. After release, a new beat 0x000000001 emerges as 0x00000001 with no stale beat first.
